// File: rtl/plab4_net_traffic_endpoint_pkg.sv
// Shared definitions for the ring-network traffic endpoint: pattern codes,
// FSM state encoding, LFSR constants and saturating arithmetic helpers.
package plab4_net_traffic_endpoint_pkg;

  // Destination-generation pattern codes
  typedef enum logic [1:0] {
    PLAB4_NET_PAT_RAND    = 2'd0,
    PLAB4_NET_PAT_NEIGH   = 2'd1,
    PLAB4_NET_PAT_TORNADO = 2'd2,
    PLAB4_NET_PAT_FIXED   = 2'd3
  } pat_e;

  // Endpoint FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Base seed; each endpoint XORs in its router id so ports diverge
  localparam logic [15:0] LFSR_SEED_BASE = 16'hACE1;

  // Tap positions x^16, x^14, x^13, x^11 as bit positions 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

  // 16-bit increment that sticks at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  // 32-bit accumulate of a 16-bit amount that sticks at all-ones
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [15:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {17'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/plab4_net_endpoint_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), shifting left.
// Loads its seed on reset or i_load; advances one step per cycle with i_en.
// Output is the register itself, available the cycle after a load or step.
module plab4_net_endpoint_lfsr
  import plab4_net_traffic_endpoint_pkg::*;
#(
  parameter logic [15:0] p_seed = LFSR_SEED_BASE
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_load,
  output logic [15:0] o_q
);

  logic [15:0] r_lfsr;
  logic        w_feedback;

  assign w_feedback = ^(r_lfsr & LFSR_TAP_MASK);
  assign o_q        = r_lfsr;

  // Reseed takes priority over stepping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= p_seed;
    end else if (i_load) begin
      r_lfsr <= p_seed;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[14:0], w_feedback};
    end
  end

endmodule

// File: rtl/plab4_net_traffic_endpoint.sv
// Ring-network traffic endpoint: injects num_msgs messages, sinks and checks ejected ones.
// Injection valid is a pure decode of the FSM state; message fields are all registered.
// Injection stalls with message held while net_out_rdy is low; the sink never backpressures.
// Optional feature macro: PLAB4_NET_ENDPOINT_LATENCY_EN (cycle-stamped payload, latency sum).
module plab4_net_traffic_endpoint
  import plab4_net_traffic_endpoint_pkg::*;
#(
  parameter int p_payload_nbits = 32,
  parameter int p_opaque_nbits  = 3,
  parameter int p_srcdest_nbits = 3,
  parameter int p_num_ports     = 8,
  parameter int p_router_id     = 0
)(
  input  logic                                                     clk,
  input  logic                                                     reset,
  input  logic                                                     go,
  input  logic [1:0]                                               pattern,
  input  logic [p_srcdest_nbits-1:0]                               fixed_dest,
  input  logic [15:0]                                              num_msgs,
  input  logic [15:0]                                              expect_recv,
  output logic                                                     net_out_val,
  input  logic                                                     net_out_rdy,
  output logic [p_payload_nbits+p_opaque_nbits+2*p_srcdest_nbits-1:0] net_out_msg,
  input  logic                                                     net_in_val,
  output logic                                                     net_in_rdy,
  input  logic [p_payload_nbits+p_opaque_nbits+2*p_srcdest_nbits-1:0] net_in_msg,
  output logic                                                     busy,
  output logic                                                     done,
  output logic [15:0]                                              sent_count,
  output logic [15:0]                                              recv_count,
  output logic                                                     err,
  output logic [31:0]                                              total_lat
);

  localparam int P = p_payload_nbits;
  localparam int O = p_opaque_nbits;
  localparam int S = p_srcdest_nbits;
  localparam int M = P + O + 2*S;

  localparam logic [15:0]  LP_SEED      = LFSR_SEED_BASE ^ 16'(p_router_id);
  localparam logic [S-1:0] LP_ID        = S'(p_router_id);
  localparam logic [S-1:0] LP_PORT_MASK = S'(p_num_ports - 1);

  // FSM and latched configuration
  state_e       r_state;
  pat_e         r_pattern;
  logic [S-1:0] r_fixed_dest;
  logic [15:0]  r_num;
  logic [15:0]  r_expect;

  // Counters and sticky error
  logic [15:0]  r_sent;
  logic [15:0]  r_recv;
  logic         r_err;

  logic         w_go_acc;
  logic         w_out_fire;
  logic         w_in_fire;
  logic         w_in_dest_bad;
  logic [15:0]  w_sent_inc;
  logic [15:0]  w_lfsr;
  logic [S-1:0] w_dest_raw;
  logic [S-1:0] w_dest;
  logic [P-1:0] w_payload;
  logic         w_unused_bits;

  // go is honoured only when no run is in progress
  assign w_go_acc      = go && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign net_out_val   = (r_state == ST_SEND);
  assign w_out_fire    = net_out_val && net_out_rdy;
  assign net_in_rdy    = !reset;
  assign w_in_fire     = net_in_val && net_in_rdy;
  assign w_in_dest_bad = (net_in_msg[M-1 -: S] != LP_ID);
  assign w_sent_inc    = sat_inc16(r_sent);

  assign busy       = (r_state == ST_SEND) || (r_state == ST_WAIT);
  assign done       = (r_state == ST_DONE);
  assign sent_count = r_sent;
  assign recv_count = r_recv;
  assign err        = r_err;

  // Only the low dest bits of the LFSR and the dest field of ejected messages matter here
  assign w_unused_bits = ^{net_in_msg, w_lfsr};

  plab4_net_endpoint_lfsr #(
    .p_seed (LP_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (reset),
    .i_en   (w_out_fire),
    .i_load (w_go_acc),
    .o_q    (w_lfsr)
  );

  // Destination selection; every pattern is reduced modulo the ring size
  always_comb begin
    w_dest_raw = '0;
    case (r_pattern)
      PLAB4_NET_PAT_RAND:    w_dest_raw = S'(w_lfsr);
      PLAB4_NET_PAT_NEIGH:   w_dest_raw = S'(p_router_id + 1);
      PLAB4_NET_PAT_TORNADO: w_dest_raw = S'(p_router_id + p_num_ports/2);
      PLAB4_NET_PAT_FIXED:   w_dest_raw = r_fixed_dest;
      default:               w_dest_raw = '0;
    endcase
  end

  assign w_dest      = w_dest_raw & LP_PORT_MASK;
  assign net_out_msg = {w_dest, LP_ID, O'(r_sent), w_payload};

`ifdef PLAB4_NET_ENDPOINT_LATENCY_EN
  logic [15:0] r_cycle;
  logic [15:0] w_lat_delta;
  logic [31:0] r_total_lat;

  // Free-running timestamp; wraps modulo 2^16
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cycle <= 16'd0;
    else       r_cycle <= r_cycle + 16'd1;
  end

  assign w_payload   = P'(r_cycle);
  assign w_lat_delta = r_cycle - net_in_msg[15:0];
  assign total_lat   = r_total_lat;

  // Latency accumulator; an arrival coincident with go counts after the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_total_lat <= 32'd0;
    end else if (w_go_acc) begin
      r_total_lat <= w_in_fire ? {16'd0, w_lat_delta} : 32'd0;
    end else if (w_in_fire) begin
      r_total_lat <= sat_add32(r_total_lat, w_lat_delta);
    end
  end
`else
  assign w_payload = P'(r_sent);
  assign total_lat = 32'd0;
`endif

  // Main FSM with counters, sink accounting and config latching
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_pattern    <= PLAB4_NET_PAT_RAND;
      r_fixed_dest <= '0;
      r_num        <= 16'd0;
      r_expect     <= 16'd0;
      r_sent       <= 16'd0;
      r_recv       <= 16'd0;
      r_err        <= 1'b0;
    end else if (w_go_acc) begin
      r_pattern    <= pat_e'(pattern);
      r_fixed_dest <= fixed_dest;
      r_num        <= num_msgs;
      r_expect     <= expect_recv;
      r_sent       <= 16'd0;
      r_recv       <= {15'd0, w_in_fire};
      r_err        <= w_in_fire && w_in_dest_bad;
      r_state      <= (num_msgs == 16'd0) ? ST_WAIT : ST_SEND;
    end else begin
      if (w_in_fire) begin
        r_recv <= sat_inc16(r_recv);
        if (w_in_dest_bad) r_err <= 1'b1;
      end
      case (r_state)
        ST_SEND: begin
          if (w_out_fire) begin
            r_sent <= w_sent_inc;
            if (w_sent_inc == r_num) r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_recv >= r_expect) r_state <= ST_DONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_plab4_net_traffic_endpoint.sv
// Scoreboard bench for the traffic endpoint: expected injections are queued at go
// and compared at each injection fire; sink, FSM and reset behaviour checked inline.
module tb_plab4_net_traffic_endpoint;

  localparam int M = 41;

`ifdef PLAB4_NET_ENDPOINT_LATENCY_EN
  localparam logic [M-1:0] MSK = {25'h1FF_FFFF, 16'h0};
`else
  localparam logic [M-1:0] MSK = {M{1'b1}};
`endif

  typedef struct packed {
    logic [2:0]  dest;
    logic [2:0]  src;
    logic [2:0]  opq;
    logic [31:0] pay;
  } msg_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         go, go7;
  logic [1:0]   pattern;
  logic [2:0]   fixed_dest;
  logic [15:0]  num_msgs, expect_recv;
  logic         out_val, out_rdy, in_val, in_rdy;
  logic [M-1:0] out_msg, in_msg;
  logic         busy, done, err;
  logic [15:0]  sent, recv;
  logic [31:0]  total_lat;

  logic         out_val7, in_rdy7, busy7, done7, err7;
  logic [M-1:0] out_msg7;
  logic [15:0]  sent7, recv7;
  logic [31:0]  total_lat7;

  logic         tb_in_val;
  logic [M-1:0] tb_in_msg;
  int           lb_mode;
  logic [2:0]   d_val;
  logic [M-1:0] d_msg [3];

  msg_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // Sink input: 0 bench-driven, 1 direct loopback, 2 loopback through a 3-cycle delay
  assign in_val = (lb_mode == 1) ? (out_val && out_rdy) :
                  (lb_mode == 2) ? d_val[2] : tb_in_val;
  assign in_msg = (lb_mode == 1) ? out_msg :
                  (lb_mode == 2) ? d_msg[2] : tb_in_msg;

  always @(posedge clk) begin
    d_val[0] <= out_val && out_rdy;
    d_msg[0] <= out_msg;
    d_val[1] <= d_val[0];
    d_msg[1] <= d_msg[0];
    d_val[2] <= d_val[1];
    d_msg[2] <= d_msg[1];
  end

  plab4_net_traffic_endpoint #(
    .p_payload_nbits(32), .p_opaque_nbits(3), .p_srcdest_nbits(3),
    .p_num_ports(8), .p_router_id(2)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .pattern(pattern), .fixed_dest(fixed_dest),
    .num_msgs(num_msgs), .expect_recv(expect_recv),
    .net_out_val(out_val), .net_out_rdy(out_rdy), .net_out_msg(out_msg),
    .net_in_val(in_val), .net_in_rdy(in_rdy), .net_in_msg(in_msg),
    .busy(busy), .done(done), .sent_count(sent), .recv_count(recv),
    .err(err), .total_lat(total_lat)
  );

  plab4_net_traffic_endpoint #(
    .p_payload_nbits(32), .p_opaque_nbits(3), .p_srcdest_nbits(3),
    .p_num_ports(8), .p_router_id(7)
  ) dut7 (
    .clk(clk), .reset(reset), .go(go7), .pattern(pattern), .fixed_dest(fixed_dest),
    .num_msgs(num_msgs), .expect_recv(expect_recv),
    .net_out_val(out_val7), .net_out_rdy(out_rdy), .net_out_msg(out_msg7),
    .net_in_val(1'b0), .net_in_rdy(in_rdy7), .net_in_msg({M{1'b0}}),
    .busy(busy7), .done(done7), .sent_count(sent7), .recv_count(recv7),
    .err(err7), .total_lat(total_lat7)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent LFSR model: taps at bits 15, 13, 12, 10
  function automatic logic [15:0] lfsr_next(input logic [15:0] r);
    return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
  endfunction

  task automatic test_reset();
    reset = 1'b1; go = 1'b0; go7 = 1'b0; pattern = 2'd0; fixed_dest = 3'd0;
    num_msgs = 16'd0; expect_recv = 16'd0; out_rdy = 1'b1;
    tb_in_val = 1'b0; tb_in_msg = '0; lb_mode = 0;
    #1;
    n_checks++;
    if ({out_val, busy, done, err, in_rdy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {out_val, busy, done, err, in_rdy});
    end
    repeat (2) tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (sent !== 16'd0 || recv !== 16'd0 || total_lat !== 32'd0) begin
      n_fail++; $display("FAIL reset_counts: got sent=%0d recv=%0d lat=%0d want 0 0 0", sent, recv, total_lat);
    end
    n_checks++;
    if (in_rdy !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: got rdy=%b busy=%b done=%b want 1 0 0", in_rdy, busy, done);
    end
  endtask

  task automatic test_loopback();
    int   fires;
    msg_t e;
    lb_mode = 1; out_rdy = 1'b1;
    pattern = 2'd3; fixed_dest = 3'd2; num_msgs = 16'd4; expect_recv = 16'd4;
    for (int k = 0; k < 4; k++) exp_q.push_back('{dest: 3'd2, src: 3'd2, opq: k[2:0], pay: 32'(k)});
    go = 1'b1; tick(); go = 1'b0;
    fires = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (out_val && out_rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL loopback_extra: got msg %h want none", out_msg);
        end else begin
          e = exp_q.pop_front();
          if ((out_msg & MSK) !== (e & MSK)) begin
            n_fail++; $display("FAIL loopback_msg: got %h want %h", out_msg, e);
          end
        end
        fires++;
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || fires != 4) begin
      n_fail++; $display("FAIL loopback_done: got done=%b fires=%0d want 1 4", done, fires);
    end
    n_checks++;
    if (sent !== 16'd4 || recv !== 16'd4 || err !== 1'b0 || total_lat !== 32'd0) begin
      n_fail++; $display("FAIL loopback_counts: got sent=%0d recv=%0d err=%b lat=%0d want 4 4 0 0", sent, recv, err, total_lat);
    end
  endtask

  task automatic test_patterns();
    msg_t e;
    lb_mode = 0; out_rdy = 1'b1;
    for (int p = 1; p <= 2; p++) begin
      pattern = p[1:0]; num_msgs = 16'd3; expect_recv = 16'd0;
      for (int k = 0; k < 3; k++)
        exp_q.push_back('{dest: (p == 1) ? 3'd0 : 3'd3, src: 3'd7, opq: k[2:0], pay: 32'(k)});
      go7 = 1'b1; tick(); go7 = 1'b0;
      for (int c = 0; c < 40 && !done7; c++) begin
        if (out_val7 && out_rdy) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL pattern_extra: got msg %h want none", out_msg7);
          end else begin
            e = exp_q.pop_front();
            if ((out_msg7 & MSK) !== (e & MSK)) begin
              n_fail++; $display("FAIL pattern%0d_msg: got %h want %h", p, out_msg7, e);
            end
          end
        end
        tick();
      end
      n_checks++;
      if (done7 !== 1'b1 || sent7 !== 16'd3 || exp_q.size() != 0) begin
        n_fail++; $display("FAIL pattern%0d_done: got done=%b sent=%0d left=%0d want 1 3 0", p, done7, sent7, exp_q.size());
      end
    end
  endtask

  task automatic test_backpressure();
    int          fires;
    bit          stalled;
    bit          exp_err;
    logic [15:0] r;
    logic [M-1:0] held;
    msg_t        e;
    lb_mode = 1; out_rdy = 1'b1;
    pattern = 2'd0; num_msgs = 16'd6; expect_recv = 16'd6;
    r = 16'hACE1 ^ 16'd2;
    exp_err = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back('{dest: r[2:0], src: 3'd2, opq: k[2:0], pay: 32'(k)});
      if (r[2:0] != 3'd2) exp_err = 1'b1;
      r = lfsr_next(r);
    end
    go = 1'b1; tick(); go = 1'b0;
    fires = 0; stalled = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      if (fires == 2 && !stalled) begin
        stalled = 1'b1; out_rdy = 1'b0; held = out_msg;
        for (int s = 0; s < 5; s++) begin
          tick();
          n_checks++;
          if (out_val !== 1'b1 || out_msg !== held || sent !== 16'd2) begin
            n_fail++; $display("FAIL stall_hold: got val=%b msg=%h sent=%0d want 1 %h 2", out_val, out_msg, sent, held);
          end
        end
        out_rdy = 1'b1;
      end
      if (out_val && out_rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stall_extra: got msg %h want none", out_msg);
        end else begin
          e = exp_q.pop_front();
          if ((out_msg & MSK) !== (e & MSK)) begin
            n_fail++; $display("FAIL rand_msg: got %h want %h", out_msg, e);
          end
        end
        fires++;
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || sent !== 16'd6 || recv !== 16'd6 || err !== exp_err) begin
      n_fail++; $display("FAIL rand_done: got done=%b sent=%0d recv=%0d err=%b want 1 6 6 %b", done, sent, recv, err, exp_err);
    end
  endtask

  task automatic test_dest_err();
    lb_mode = 0; tb_in_val = 1'b0;
    pattern = 2'd3; fixed_dest = 3'd2; num_msgs = 16'd0; expect_recv = 16'd5;
    go = 1'b1; tick(); go = 1'b0;
    tb_in_val = 1'b1; tb_in_msg = {3'd5, 3'd0, 3'd0, 32'd0};
    tick();
    tb_in_val = 1'b0;
    n_checks++;
    if (err !== 1'b1 || recv !== 16'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bad_dest: got err=%b recv=%0d busy=%b want 1 1 1", err, recv, busy);
    end
    go = 1'b1; repeat (3) tick(); go = 1'b0;
    n_checks++;
    if (err !== 1'b1 || recv !== 16'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got err=%b recv=%0d busy=%b want 1 1 1", err, recv, busy);
    end
    tb_in_val = 1'b1; tb_in_msg = {3'd2, 3'd1, 3'd0, 32'd9};
    repeat (4) tick();
    tb_in_val = 1'b0;
    tick();
    n_checks++;
    if (done !== 1'b1 || recv !== 16'd5 || err !== 1'b1) begin
      n_fail++; $display("FAIL wait_done: got done=%b recv=%0d err=%b want 1 5 1", done, recv, err);
    end
    num_msgs = 16'd0; expect_recv = 16'd0;
    go = 1'b1; tb_in_val = 1'b1;
    tick();
    go = 1'b0; tb_in_val = 1'b0;
    n_checks++;
    if (err !== 1'b0 || recv !== 16'd1 || sent !== 16'd0) begin
      n_fail++; $display("FAIL go_clear: got err=%b recv=%0d sent=%0d want 0 1 0", err, recv, sent);
    end
    tick();
  endtask

  task automatic test_zero_msgs();
    lb_mode = 0; tb_in_val = 1'b0;
    num_msgs = 16'd0; expect_recv = 16'd0;
    go = 1'b1; tick(); go = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || out_val !== 1'b0 || recv !== 16'd0) begin
      n_fail++; $display("FAIL zero_wait: got busy=%b done=%b val=%b recv=%0d want 1 0 0 0", busy, done, out_val, recv);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sent !== 16'd0) begin
      n_fail++; $display("FAIL zero_done: got done=%b busy=%b sent=%0d want 1 0 0", done, busy, sent);
    end
  endtask

  task automatic test_reset_mid_send();
    int          fires;
    logic [15:0] r;
    msg_t        e;
    lb_mode = 1; out_rdy = 1'b1;
    pattern = 2'd3; fixed_dest = 3'd2; num_msgs = 16'd5; expect_recv = 16'd5;
    go = 1'b1; tick(); go = 1'b0;
    fires = 0;
    for (int c = 0; c < 20 && fires < 2; c++) begin
      if (out_val && out_rdy) fires++;
      tick();
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({out_val, busy, done, err, in_rdy} !== 5'b0 || sent !== 16'd0 || recv !== 16'd0 || total_lat !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset: got flags=%b sent=%0d recv=%0d lat=%0d want 00000 0 0 0",
                         {out_val, busy, done, err, in_rdy}, sent, recv, total_lat);
    end
    tick();
    reset = 1'b0;
    exp_q.delete();
    tick();
    pattern = 2'd0; num_msgs = 16'd2; expect_recv = 16'd2;
    r = 16'hACE1 ^ 16'd2;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{dest: r[2:0], src: 3'd2, opq: k[2:0], pay: 32'(k)});
      r = lfsr_next(r);
    end
    go = 1'b1; tick(); go = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      if (out_val && out_rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL reseed_extra: got msg %h want none", out_msg);
        end else begin
          e = exp_q.pop_front();
          if ((out_msg & MSK) !== (e & MSK)) begin
            n_fail++; $display("FAIL reseed_msg: got %h want %h", out_msg, e);
          end
        end
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || sent !== 16'd2) begin
      n_fail++; $display("FAIL reseed_done: got done=%b sent=%0d want 1 2", done, sent);
    end
  endtask

`ifdef PLAB4_NET_ENDPOINT_LATENCY_EN
  task automatic test_latency();
    lb_mode = 2; out_rdy = 1'b1;
    pattern = 2'd3; fixed_dest = 3'd2; num_msgs = 16'd10; expect_recv = 16'd10;
    go = 1'b1; tick(); go = 1'b0;
    for (int c = 0; c < 200 && !done; c++) tick();
    n_checks++;
    if (done !== 1'b1 || recv !== 16'd10 || total_lat !== 32'd30) begin
      n_fail++; $display("FAIL latency_sum: got done=%b recv=%0d lat=%0d want 1 10 30", done, recv, total_lat);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_loopback();
    test_patterns();
    test_backpressure();
    test_dest_err();
    test_zero_msgs();
    test_reset_mid_send();
`ifdef PLAB4_NET_ENDPOINT_LATENCY_EN
    test_latency();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
